// File: rtl/bram_read_streamer.sv
// Streams a contiguous BRAM address range out on a valid/ready port and checks each word against its address.
// Latency: the first word appears RD_LATENCY+2 cycles after start. Reads are throttled so FIFO plus in-flight never exceeds 4.
// Backpressure: m_ready low stops issue once 4 words are held or outstanding; no word is ever dropped.
module bram_read_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_100mhz,
    input  logic                  reset_n,
    input  logic                  locked,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] read_data_in,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count
);
    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           issued;
    logic [LW-1:0]           out_idx;
    logic [RD_LATENCY-1:0]   pipe;
    logic [DATA_WIDTH-1:0]   mem [4];
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [2:0]              occ;
    logic [2:0]              outstanding;
    logic                    capture;
    logic                    xfer;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   exp_addr;
    logic [DATA_WIDTH-1:0]   exp_data;

    // Outstanding reads include the one currently on the BRAM port.
    always_comb begin
        outstanding = {2'b00, read_en};
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding = outstanding + {2'b00, pipe[i]};
        end
    end

    assign capture  = pipe[RD_LATENCY-1];
    assign m_valid  = (occ != 3'd0);
    assign m_data   = mem[rd_ptr];
    assign m_last   = m_valid && (out_idx == len_q - LW'(1));
    assign xfer     = m_valid && m_ready;
    assign busy     = (state != IDLE);
    assign issue    = (state == READ) && locked && (issued != len_q)
                      && (({1'b0, occ} + {1'b0, outstanding}) < 4'd4);
    assign exp_addr = base_q + out_idx[ADDR_WIDTH-1:0];
    assign exp_data = DATA_WIDTH'(exp_addr);

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            out_idx   <= '0;
            read_en   <= 1'b0;
            read_addr <= '0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            done    <= 1'b0;
            read_en <= issue;
            if (issue) begin
                read_addr <= base_q + issued[ADDR_WIDTH-1:0];
                issued    <= issued + LW'(1);
            end
            if (xfer) begin
                out_idx <= out_idx + LW'(1);
                if (m_data != exp_data && err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (start && locked) begin
                        base_q  <= base_addr;
                        len_q   <= length;
                        issued  <= '0;
                        out_idx <= '0;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue && (issued + LW'(1) == len_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer && m_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-data pipeline and 4-entry output FIFO; capture keeps running even while locked is low.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            pipe   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pipe[0] <= read_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (capture) begin
                mem[wr_ptr] <= read_data_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            occ <= occ + {2'b00, capture} - {2'b00, xfer};
        end
    end

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed bench for bram_read_streamer with a latency-1 BRAM model and a transfer monitor.
module tb_bram_read_streamer;
    logic        clk_100mhz = 1'b0;
    logic        reset_n;
    logic        locked;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [31:0] read_data_in;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] bram [1024];
    logic [31:0] wq [$];
    bit          lq [$];
    logic [9:0]  aq [$];
    int          rd_cnt, x_cnt, done_cnt, max_out;
    bit          mon_clr;

    bram_read_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1)) dut (
        .clk_100mhz(clk_100mhz), .reset_n(reset_n), .locked(locked), .start(start),
        .base_addr(base_addr), .length(length), .read_addr(read_addr), .read_en(read_en),
        .read_data_in(read_data_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done), .err_count(err_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) begin
        if (read_en) read_data_in <= bram[read_addr];
    end

    always @(posedge clk_100mhz) begin
        if (mon_clr) begin
            wq.delete(); lq.delete(); aq.delete();
            rd_cnt <= 0; x_cnt <= 0; done_cnt <= 0; max_out <= 0;
        end else begin
            if (read_en) begin aq.push_back(read_addr); rd_cnt <= rd_cnt + 1; end
            if (m_valid && m_ready) begin wq.push_back(m_data); lq.push_back(m_last); x_cnt <= x_cnt + 1; end
            if (done) done_cnt <= done_cnt + 1;
            if (rd_cnt - x_cnt > max_out) max_out <= rd_cnt - x_cnt;
        end
    end

    task automatic clear_mon();
        @(negedge clk_100mhz); mon_clr = 1'b1;
        @(negedge clk_100mhz); mon_clr = 1'b0;
    endtask

    task automatic start_pulse(input logic [9:0] b, input logic [10:0] l);
        @(negedge clk_100mhz);
        base_addr = b; length = l; start = 1'b1;
        @(negedge clk_100mhz);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100mhz);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_xfers(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100mhz);
            if (x_cnt >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++; if (read_en !== 1'b0 || read_addr !== 10'd0) begin errors++; $display("FAIL reset_read got en=%b addr=%0d want 0/0", read_en, read_addr); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'd0) begin errors++; $display("FAIL reset_stream got v=%b l=%b d=%h want 0", m_valid, m_last, m_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'd0) begin errors++; $display("FAIL reset_status got busy=%b done=%b err=%0d want 0", busy, done, err_count); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        start_pulse(10'd5, 11'd4);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done got timeout want done"); end
        @(negedge clk_100mhz);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", wq.size()); end
        for (int i = 0; i < wq.size() && i < 4; i++) begin
            checks++; if (wq[i] !== 32'(5 + i) || lq[i] !== (i == 3)) begin errors++; $display("FAIL basic_word%0d got %0d last=%b want %0d last=%b", i, wq[i], lq[i], 5 + i, i == 3); end
        end
        checks++; if (done_cnt != 1 || err_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL basic_status got done=%0d err=%0d busy=%b want 1/0/0", done_cnt, err_count, busy); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [9:0] ea [4];
        ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0; ea[3] = 10'd1;
        clear_mon();
        start_pulse(10'd1022, 11'd4);
        wait_done(200, ok);
        checks++; if (!ok || aq.size() != 4 || wq.size() != 4) begin errors++; $display("FAIL wrap_count got ok=%b reads=%0d words=%0d want 1/4/4", ok, aq.size(), wq.size()); end
        for (int i = 0; i < aq.size() && i < 4 && i < wq.size(); i++) begin
            checks++; if (aq[i] !== ea[i] || wq[i] !== 32'(ea[i])) begin errors++; $display("FAIL wrap_%0d got addr=%0d data=%0d want %0d", i, aq[i], wq[i], ea[i]); end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL wrap_err got %0d want 0", err_count); end
    endtask

    task automatic test_error();
        bit ok;
        bram[6] = 32'hDEAD_BEEF;
        clear_mon();
        start_pulse(10'd5, 11'd4);
        wait_done(200, ok);
        @(negedge clk_100mhz);
        checks++; if (!ok || err_count !== 16'd1) begin errors++; $display("FAIL error_count got ok=%b err=%0d want 1/1", ok, err_count); end
        bram[6] = 32'd6;
        start_pulse(10'd5, 11'd4);
        wait_done(200, ok);
        @(negedge clk_100mhz);
        checks++; if (!ok || err_count !== 16'd1) begin errors++; $display("FAIL error_persist got ok=%b err=%0d want 1/1", ok, err_count); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        start_pulse(10'd50, 11'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b busy=%b want 1/0", done, busy); end
        @(negedge clk_100mhz);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse got done=%b want 0", done); end
        repeat (5) @(negedge clk_100mhz);
        checks++; if (rd_cnt != 0 || busy !== 1'b0 || x_cnt != 0) begin errors++; $display("FAIL zero_idle got reads=%0d busy=%b words=%0d want 0", rd_cnt, busy, x_cnt); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        clear_mon();
        start_pulse(10'd200, 11'd6);
        @(negedge clk_100mhz);
        base_addr = 10'd300; length = 11'd2; start = 1'b1;
        @(negedge clk_100mhz); start = 1'b0;
        wait_done(200, ok);
        repeat (10) @(negedge clk_100mhz);
        checks++; if (!ok || wq.size() != 6 || rd_cnt != 6 || done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_ignore got ok=%b words=%0d reads=%0d done=%0d busy=%b want 1/6/6/1/0", ok, wq.size(), rd_cnt, done_cnt, busy); end
        for (int i = 0; i < wq.size() && i < 6; i++) begin
            checks++; if (wq[i] !== 32'(200 + i)) begin errors++; $display("FAIL busy_word%0d got %0d want %0d", i, wq[i], 200 + i); end
        end
    endtask

    task automatic test_lock();
        bit ok;
        int r0;
        clear_mon();
        locked = 1'b0;
        start_pulse(10'd0, 11'd4);
        @(negedge clk_100mhz);
        checks++; if (busy !== 1'b0 || rd_cnt != 0) begin errors++; $display("FAIL lock_start got busy=%b reads=%0d want 0/0", busy, rd_cnt); end
        locked = 1'b1;
        start_pulse(10'd400, 11'd8);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100mhz);
            if (rd_cnt >= 3) begin ok = 1'b1; break; end
        end
        locked = 1'b0;
        @(negedge clk_100mhz);
        r0 = rd_cnt;
        repeat (10) @(negedge clk_100mhz);
        checks++; if (!ok || rd_cnt != r0 || busy !== 1'b1) begin errors++; $display("FAIL lock_stall got reads=%0d busy=%b want %0d/1", rd_cnt, busy, r0); end
        locked = 1'b1;
        wait_done(200, ok);
        checks++; if (!ok || wq.size() != 8) begin errors++; $display("FAIL lock_resume got ok=%b words=%0d want 1/8", ok, wq.size()); end
        for (int i = 0; i < wq.size() && i < 8; i++) begin
            checks++; if (wq[i] !== 32'(400 + i)) begin errors++; $display("FAIL lock_word%0d got %0d want %0d", i, wq[i], 400 + i); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        logic [31:0] pd;
        logic        pv;
        clear_mon();
        start_pulse(10'd100, 11'd12);
        wait_xfers(2, 100, ok);
        m_ready = 1'b0;
        stable = 1'b1; pd = m_data; pv = m_valid;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100mhz);
            if (pv && (!m_valid || m_data !== pd)) stable = 1'b0;
            pd = m_data; pv = m_valid;
        end
        checks++; if (!ok || !stable || m_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got ok=%b stable=%b valid=%b want 1/1/1", ok, stable, m_valid); end
        checks++; if (rd_cnt - x_cnt != 4) begin errors++; $display("FAIL bp_outstanding got %0d want 4", rd_cnt - x_cnt); end
        m_ready = 1'b1;
        wait_done(200, ok);
        checks++; if (!ok || wq.size() != 12 || max_out > 4) begin errors++; $display("FAIL bp_finish got ok=%b words=%0d max_out=%0d want 1/12/<=4", ok, wq.size(), max_out); end
        for (int i = 0; i < wq.size() && i < 12; i++) begin
            checks++; if (wq[i] !== 32'(100 + i) || lq[i] !== (i == 11)) begin errors++; $display("FAIL bp_word%0d got %0d last=%b want %0d", i, wq[i], lq[i], 100 + i); end
        end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        clear_mon();
        start_pulse(10'd0, 11'd16);
        wait_xfers(2, 100, ok);
        reset_n = 1'b0;
        #1;
        checks++; if (!ok || read_en !== 1'b0 || read_addr !== 10'd0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'd0) begin errors++; $display("FAIL midreset_outputs got ok=%b en=%b addr=%0d v=%b l=%b d=%h want 1/0", ok, read_en, read_addr, m_valid, m_last, m_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'd0) begin errors++; $display("FAIL midreset_status got busy=%b done=%b err=%0d want 0", busy, done, err_count); end
        repeat (2) @(negedge clk_100mhz);
        reset_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk_100mhz);
        checks++; if (done_cnt != 0 || busy !== 1'b0 || x_cnt != 0 || rd_cnt != 0) begin errors++; $display("FAIL midreset_quiet got done=%0d busy=%b words=%0d reads=%0d want 0", done_cnt, busy, x_cnt, rd_cnt); end
        start_pulse(10'd5, 11'd4);
        wait_done(200, ok);
        @(negedge clk_100mhz);
        checks++; if (!ok || wq.size() != 4 || err_count !== 16'd0 || done_cnt != 1) begin errors++; $display("FAIL midreset_rerun got ok=%b words=%0d err=%0d done=%0d want 1/4/0/1", ok, wq.size(), err_count, done_cnt); end
        for (int i = 0; i < wq.size() && i < 4; i++) begin
            checks++; if (wq[i] !== 32'(5 + i)) begin errors++; $display("FAIL midreset_word%0d got %0d want %0d", i, wq[i], 5 + i); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = 32'(i);
        reset_n = 1'b0; locked = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        m_ready = 1'b1; mon_clr = 1'b1;
        test_reset();
        repeat (3) @(negedge clk_100mhz);
        reset_n = 1'b1;
        mon_clr = 1'b0;
        test_basic();
        test_wrap();
        test_error();
        test_zero_len();
        test_busy_ignore();
        test_lock();
        test_backpressure();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
